// File: rtl/pc_sequencer_if.sv
// Bus between the program-counter sequencer and its surrounding datapath:
// decoded control requests in, PC/stack strobes and status out.
interface pc_sequencer_if;
    logic [9:0] from_immed;
    logic [9:0] from_stack;
    logic       branch;
    logic       call;
    logic       ret;
    logic       reti;
    logic       sei;
    logic       cli;
    logic       intr;
    logic [9:0] pc_count;
    logic [1:0] pc_mux_sel;
    logic       pc_ld;
    logic       stack_push;
    logic       stack_pop;
    logic [9:0] ret_addr;
    logic       int_en;
    logic       stk_err;
    logic [1:0] state;

    modport master (
        output from_immed, from_stack, branch, call, ret, reti, sei, cli, intr,
        input  pc_count, pc_mux_sel, pc_ld, stack_push, stack_pop, ret_addr,
               int_en, stk_err, state
    );

    modport slave (
        input  from_immed, from_stack, branch, call, ret, reti, sei, cli, intr,
        output pc_count, pc_mux_sel, pc_ld, stack_push, stack_pop, ret_addr,
               int_en, stk_err, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute/interrupt sequencer owning the program counter, interrupt
// enable, edge-detected interrupt pending bit and return-stack depth tracking.
module pc_sequencer #(
    parameter logic [9:0] VECTOR    = 10'h3FF,
    parameter int         DEPTH_MAX = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);
    localparam int DW = $clog2(DEPTH_MAX + 1);
    localparam logic [DW-1:0] DEPTH_TOP = DW'(DEPTH_MAX);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_INTR  = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [9:0]    pcCount_q, pcCount_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          intEn_q, intEn_d;
    logic          pending_q, pending_d;
    logic          stkErr_q, stkErr_d;
    logic          intrPrev_q;

    logic          pcLd;
    logic          push;
    logic          pop;
    logic [1:0]    muxSel;
    logic [9:0]    retAddr;
    logic [9:0]    pcInc;
    logic          intrRise;

    assign pcInc    = pcCount_q + 10'd1;
    assign intrRise = bus.intr & ~intrPrev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            pcCount_q  <= '0;
            depth_q    <= '0;
            intEn_q    <= 1'b0;
            pending_q  <= 1'b0;
            stkErr_q   <= 1'b0;
            intrPrev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcCount_q  <= pcCount_d;
            depth_q    <= depth_d;
            intEn_q    <= intEn_d;
            pending_q  <= pending_d;
            stkErr_q   <= stkErr_d;
            intrPrev_q <= bus.intr;
        end
    end

    always_comb begin
        state_d   = state_q;
        pcCount_d = pcCount_q;
        depth_d   = depth_q;
        intEn_d   = intEn_q;
        pending_d = pending_q | intrRise;
        stkErr_d  = stkErr_q;
        pcLd      = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        muxSel    = 2'b11;
        retAddr   = '0;

        case (state_q)
            S_INIT: begin
                pcLd    = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // A pop on an empty stack falls back to the zero source.
                if (bus.ret || bus.reti) begin
                    pcLd = 1'b1;
                    if (depth_q == '0) begin
                        stkErr_d = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        muxSel  = 2'b01;
                        depth_d = depth_q - DEPTH_ONE;
                    end
                end else if (bus.call) begin
                    pcLd   = 1'b1;
                    muxSel = 2'b00;
                    if (depth_q == DEPTH_TOP) begin
                        stkErr_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        retAddr = pcInc;
                        depth_d = depth_q + DEPTH_ONE;
                    end
                end else if (bus.branch) begin
                    pcLd   = 1'b1;
                    muxSel = 2'b00;
                end

                if (bus.cli) begin
                    intEn_d = 1'b0;
                end else if (bus.sei || bus.reti) begin
                    intEn_d = 1'b1;
                end

                // The interrupt decision sees this instruction's enable update.
                state_d = (pending_d && intEn_d) ? S_INTR : S_FETCH;
            end
            S_INTR: begin
                pcLd      = 1'b1;
                muxSel    = 2'b10;
                intEn_d   = 1'b0;
                pending_d = intrRise;
                if (depth_q == DEPTH_TOP) begin
                    stkErr_d = 1'b1;
                end else begin
                    push    = 1'b1;
                    retAddr = pcCount_q;
                    depth_d = depth_q + DEPTH_ONE;
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        if (pcLd) begin
            case (muxSel)
                2'b00:   pcCount_d = bus.from_immed;
                2'b01:   pcCount_d = bus.from_stack;
                2'b10:   pcCount_d = VECTOR;
                default: pcCount_d = '0;
            endcase
        end else if (state_q == S_EXEC) begin
            pcCount_d = pcInc;
        end
    end

    // INIT requests a load, but no strobe may escape while reset is held.
    assign bus.pc_ld      = pcLd & rst_n;
    assign bus.pc_mux_sel = muxSel;
    assign bus.stack_push = push;
    assign bus.stack_pop  = pop;
    assign bus.ret_addr   = retAddr;
    assign bus.pc_count   = pcCount_q;
    assign bus.int_en     = intEn_q;
    assign bus.stk_err    = stkErr_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: stack pushes/pops are checked against a
// queue of expected events; PC, state and flags are checked inline per scenario.
module tb_pc_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct {
        logic       isPush;
        logic [9:0] addr;
    } ev_t;

    ev_t  expQ[$];
    ev_t  monEv;
    logic ld;
    logic [1:0] sel;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .VECTOR    (10'h3FF),
        .DEPTH_MAX (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every stack strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (bus.stack_push || bus.stack_pop) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL stack_event: got push=%b pop=%b addr=%h, required no strobe",
                         bus.stack_push, bus.stack_pop, bus.ret_addr);
            end else begin
                monEv = expQ.pop_front();
                if (bus.stack_push !== monEv.isPush || bus.stack_pop !== ~monEv.isPush ||
                    (monEv.isPush && bus.ret_addr !== monEv.addr)) begin
                    errors++;
                    $display("[TB] FAIL stack_event: got push=%b pop=%b addr=%h, required push=%b addr=%h",
                             bus.stack_push, bus.stack_pop, bus.ret_addr, monEv.isPush, monEv.addr);
                end
            end
        end
        if (rst_n) begin
            checks++;
            if (!bus.pc_ld && bus.pc_mux_sel !== 2'b11) begin
                errors++;
                $display("[TB] FAIL idle_mux: got sel=%b with pc_ld=0, required 11", bus.pc_mux_sel);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got time limit expired, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearInputs();
        bus.branch     = 1'b0;
        bus.call       = 1'b0;
        bus.ret        = 1'b0;
        bus.reti       = 1'b0;
        bus.sei        = 1'b0;
        bus.cli        = 1'b0;
        bus.intr       = 1'b0;
        bus.from_immed = '0;
        bus.from_stack = '0;
    endtask

    // Called just after an edge that entered FETCH; returns just after EXEC exits.
    task automatic runInstr(input logic b, input logic c, input logic r, input logic ri,
                            input logic s, input logic cl, input logic pulse,
                            input logic [9:0] imm, input logic [9:0] stk,
                            output logic ldSeen, output logic [1:0] selSeen);
        bus.branch     = b;
        bus.call       = c;
        bus.ret        = r;
        bus.reti       = ri;
        bus.sei        = s;
        bus.cli        = cl;
        bus.intr       = pulse;
        bus.from_immed = imm;
        bus.from_stack = stk;
        @(posedge clk);
        @(negedge clk);
        ldSeen   = bus.pc_ld;
        selSeen  = bus.pc_mux_sel;
        bus.intr = 1'b0;
        @(posedge clk);
        #1;
        clearInputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearInputs();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.state !== 2'b00 || bus.pc_count !== 10'h000) begin
            errors++;
            $display("[TB] FAIL reset_state_pc: got state=%b pc=%h, required 00 000", bus.state, bus.pc_count);
        end
        checks++;
        if ({bus.pc_ld, bus.stack_push, bus.stack_pop} !== 3'b000 || bus.pc_mux_sel !== 2'b11) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got ld/push/pop=%b sel=%b, required 000 11",
                     {bus.pc_ld, bus.stack_push, bus.stack_pop}, bus.pc_mux_sel);
        end
        checks++;
        if ({bus.int_en, bus.stk_err} !== 2'b00 || bus.ret_addr !== 10'h000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got int_en/stk_err=%b ret_addr=%h, required 00 000",
                     {bus.int_en, bus.stk_err}, bus.ret_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.state !== 2'b00 || bus.pc_ld !== 1'b1 || bus.pc_mux_sel !== 2'b11) begin
            errors++;
            $display("[TB] FAIL init_load: got state=%b ld=%b sel=%b, required 00 1 11",
                     bus.state, bus.pc_ld, bus.pc_mux_sel);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 2'b01 || bus.pc_count !== 10'h000) begin
            errors++;
            $display("[TB] FAIL init_to_fetch: got state=%b pc=%h, required 01 000", bus.state, bus.pc_count);
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            runInstr(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, ld, sel);
            checks++;
            if (bus.pc_count !== 10'(i) || bus.state !== 2'b01 || ld !== 1'b0) begin
                errors++;
                $display("[TB] FAIL seq_pc_%0d: got pc=%h state=%b ld=%b, required %h 01 0",
                         i, bus.pc_count, bus.state, ld, 10'(i));
            end
        end
        runInstr(1, 0, 0, 0, 0, 0, 0, 10'h3FF, 10'h000, ld, sel);
        checks++;
        if (bus.pc_count !== 10'h3FF || ld !== 1'b1 || sel !== 2'b00) begin
            errors++;
            $display("[TB] FAIL branch: got pc=%h ld=%b sel=%b, required 3ff 1 00", bus.pc_count, ld, sel);
        end
        runInstr(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, ld, sel);
        checks++;
        if (bus.pc_count !== 10'h000) begin
            errors++;
            $display("[TB] FAIL wrap: got pc=%h, required 000", bus.pc_count);
        end
    endtask

    task automatic test_call_ret();
        runInstr(1, 0, 0, 0, 0, 0, 0, 10'h010, 10'h000, ld, sel);
        expQ.push_back('{1'b1, 10'h011});
        runInstr(0, 1, 0, 0, 0, 0, 0, 10'h080, 10'h000, ld, sel);
        checks++;
        if (bus.pc_count !== 10'h080 || ld !== 1'b1 || sel !== 2'b00) begin
            errors++;
            $display("[TB] FAIL call: got pc=%h ld=%b sel=%b, required 080 1 00", bus.pc_count, ld, sel);
        end
        runInstr(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, ld, sel);
        expQ.push_back('{1'b0, 10'h000});
        runInstr(0, 0, 1, 0, 0, 0, 0, 10'h000, 10'h011, ld, sel);
        checks++;
        if (bus.pc_count !== 10'h011 || ld !== 1'b1 || sel !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ret: got pc=%h ld=%b sel=%b, required 011 1 01", bus.pc_count, ld, sel);
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL call_ret_events: got %0d pending, required 0", expQ.size());
        end
    endtask

    task automatic test_interrupt();
        runInstr(0, 0, 0, 0, 1, 0, 0, 10'h000, 10'h000, ld, sel);
        runInstr(1, 0, 0, 0, 0, 0, 0, 10'h020, 10'h000, ld, sel);
        checks++;
        if (bus.int_en !== 1'b1 || bus.pc_count !== 10'h020) begin
            errors++;
            $display("[TB] FAIL sei: got int_en=%b pc=%h, required 1 020", bus.int_en, bus.pc_count);
        end
        expQ.push_back('{1'b1, 10'h021});
        runInstr(0, 0, 0, 0, 0, 0, 1, 10'h000, 10'h000, ld, sel);
        checks++;
        if (bus.state !== 2'b11 || bus.pc_count !== 10'h021) begin
            errors++;
            $display("[TB] FAIL intr_entry: got state=%b pc=%h, required 11 021", bus.state, bus.pc_count);
        end
        @(negedge clk);
        checks++;
        if (bus.pc_ld !== 1'b1 || bus.pc_mux_sel !== 2'b10) begin
            errors++;
            $display("[TB] FAIL intr_load: got ld=%b sel=%b, required 1 10", bus.pc_ld, bus.pc_mux_sel);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 2'b01 || bus.pc_count !== 10'h3FF || bus.int_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL intr_vector: got state=%b pc=%h int_en=%b, required 01 3ff 0",
                     bus.state, bus.pc_count, bus.int_en);
        end
        expQ.push_back('{1'b0, 10'h000});
        runInstr(0, 0, 0, 1, 0, 0, 0, 10'h000, 10'h021, ld, sel);
        checks++;
        if (bus.pc_count !== 10'h021 || bus.int_en !== 1'b1 || bus.state !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reti: got pc=%h int_en=%b state=%b, required 021 1 01",
                     bus.pc_count, bus.int_en, bus.state);
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL intr_events: got %0d pending, required 0", expQ.size());
        end
    endtask

    task automatic test_int_disabled();
        runInstr(0, 0, 0, 0, 1, 1, 0, 10'h000, 10'h000, ld, sel);
        checks++;
        if (bus.int_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sei_cli_both: got int_en=%b, required 0", bus.int_en);
        end
        runInstr(1, 0, 0, 0, 0, 0, 0, 10'h100, 10'h000, ld, sel);
        runInstr(0, 0, 0, 0, 0, 0, 1, 10'h000, 10'h000, ld, sel);
        checks++;
        if (bus.state !== 2'b01 || bus.pc_count !== 10'h101) begin
            errors++;
            $display("[TB] FAIL masked_intr: got state=%b pc=%h, required 01 101", bus.state, bus.pc_count);
        end
        runInstr(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, ld, sel);
        checks++;
        if (bus.state !== 2'b01 || bus.pc_count !== 10'h102) begin
            errors++;
            $display("[TB] FAIL masked_hold: got state=%b pc=%h, required 01 102", bus.state, bus.pc_count);
        end
        expQ.push_back('{1'b1, 10'h103});
        runInstr(0, 0, 0, 0, 1, 0, 0, 10'h000, 10'h000, ld, sel);
        checks++;
        if (bus.state !== 2'b11 || bus.pc_count !== 10'h103 || bus.int_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL deferred_intr: got state=%b pc=%h int_en=%b, required 11 103 1",
                     bus.state, bus.pc_count, bus.int_en);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.pc_count !== 10'h3FF || bus.int_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL deferred_vector: got pc=%h int_en=%b, required 3ff 0", bus.pc_count, bus.int_en);
        end
        expQ.push_back('{1'b0, 10'h000});
        runInstr(0, 0, 0, 1, 0, 0, 0, 10'h000, 10'h103, ld, sel);
        checks++;
        if (bus.pc_count !== 10'h103 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL deferred_reti: got pc=%h pending=%0d, required 103 0", bus.pc_count, expQ.size());
        end
    endtask

    task automatic test_stack_err();
        runInstr(1, 0, 0, 0, 0, 0, 0, 10'h1F0, 10'h000, ld, sel);
        for (int i = 0; i < 16; i++) begin
            if (i < 15) expQ.push_back('{1'b1, (i == 0) ? 10'h1F1 : 10'h201});
            runInstr(0, 1, 0, 0, 0, 0, 0, 10'h200, 10'h000, ld, sel);
            if (i == 14) begin
                checks++;
                if (bus.stk_err !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL full_no_err: got stk_err=%b, required 0", bus.stk_err);
                end
            end
        end
        checks++;
        if (bus.stk_err !== 1'b1 || bus.pc_count !== 10'h200 || ld !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow: got stk_err=%b pc=%h ld=%b, required 1 200 1",
                     bus.stk_err, bus.pc_count, ld);
        end
        for (int i = 0; i < 15; i++) begin
            expQ.push_back('{1'b0, 10'h000});
            runInstr(0, 0, 1, 0, 0, 0, 0, 10'h000, 10'h055, ld, sel);
        end
        checks++;
        if (bus.pc_count !== 10'h055 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got pc=%h pending=%0d, required 055 0", bus.pc_count, expQ.size());
        end
        runInstr(0, 0, 1, 0, 0, 0, 0, 10'h000, 10'h055, ld, sel);
        checks++;
        if (bus.pc_count !== 10'h000 || ld !== 1'b1 || sel !== 2'b11 || bus.stk_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow: got pc=%h ld=%b sel=%b stk_err=%b, required 000 1 11 1",
                     bus.pc_count, ld, sel, bus.stk_err);
        end
    endtask

    task automatic test_reset_mid_intr();
        runInstr(0, 0, 0, 0, 1, 0, 0, 10'h000, 10'h000, ld, sel);
        runInstr(0, 0, 0, 0, 0, 0, 1, 10'h000, 10'h000, ld, sel);
        checks++;
        if (bus.state !== 2'b11) begin
            errors++;
            $display("[TB] FAIL pre_reset_intr: got state=%b, required 11", bus.state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 2'b00 || bus.pc_count !== 10'h000 || bus.int_en !== 1'b0 || bus.stk_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got state=%b pc=%h int_en=%b stk_err=%b, required 00 000 0 0",
                     bus.state, bus.pc_count, bus.int_en, bus.stk_err);
        end
        checks++;
        if ({bus.pc_ld, bus.stack_push, bus.stack_pop} !== 3'b000 || bus.pc_mux_sel !== 2'b11 ||
            bus.ret_addr !== 10'h000) begin
            errors++;
            $display("[TB] FAIL async_reset_strobes: got ld/push/pop=%b sel=%b ret_addr=%h, required 000 11 000",
                     {bus.pc_ld, bus.stack_push, bus.stack_pop}, bus.pc_mux_sel, bus.ret_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runInstr(0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, ld, sel);
        checks++;
        if (bus.state !== 2'b01 || bus.pc_count !== 10'h001 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL post_reset: got state=%b pc=%h pending=%0d, required 01 001 0",
                     bus.state, bus.pc_count, expQ.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clearInputs();
        test_reset();
        test_sequential();
        test_call_ret();
        test_interrupt();
        test_int_disabled();
        test_stack_err();
        test_reset_mid_intr();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter VECTOR, default 10'h3FF, meaning interrupt vector address.
REQ-002 SHALL have parameter DEPTH_MAX, default 15, meaning maximum return-stack occupancy.
REQ-003 SHALL have port CLK  input  1  rising-edge system clock.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port FROM_IMMED  input  10  branch/call target.
REQ-006 SHALL have port FROM_STACK  input  10  popped return address.
REQ-007 SHALL have port BRANCH  input  1  taken jump/branch, sampled in EXEC.
REQ-008 SHALL have port CALL  input  1  call, sampled in EXEC.
REQ-009 SHALL have port RET  input  1  return, sampled in EXEC.
REQ-010 SHALL have port RETI  input  1  return-from-interrupt, sampled in EXEC.
REQ-011 SHALL have port SEI  input  1  set interrupt enable, sampled in EXEC.
REQ-012 SHALL have port CLI  input  1  clear interrupt enable, sampled in EXEC.
REQ-013 SHALL have port INTR  input  1  interrupt request, level, rising-edge detected.
REQ-014 SHALL have port PC_COUNT  output  10  current program counter.
REQ-015 SHALL have port PC_MUX_SEL  output  2  select: 00 immed, 01 stack, 10 VECTOR, 11 zero.
REQ-016 SHALL have port PC_LD  output  1  one-cycle load strobe to the PC register.
REQ-017 SHALL have port STACK_PUSH  output  1  one-cycle push strobe.
REQ-018 SHALL have port STACK_POP  output  1  one-cycle pop strobe.
REQ-019 SHALL have port RET_ADDR  output  10  address to push, valid with STACK_PUSH.
REQ-020 SHALL have port INT_EN  output  1  interrupt enable flag.
REQ-021 SHALL have port STK_ERR  output  1  sticky stack overflow/underflow flag.
REQ-022 SHALL have port STATE  output  2  FSM state: 00 INIT, 01 FETCH, 10 EXEC, 11 INTR.

Function
REQ-023 SHALL implement FSM INIT -> FETCH -> EXEC -> (INTR if pending and INT_EN, else FETCH); INTR -> FETCH.
REQ-024 SHALL in INIT drive PC_MUX_SEL=11, PC_LD=1, loading PC_COUNT=0 at the next edge.
REQ-025 SHALL hold PC_COUNT constant in FETCH; all strobes 0 in FETCH.
REQ-026 SHALL on leaving EXEC update PC_COUNT per priority RET/RETI > CALL > BRANCH > sequential.
REQ-027 SHALL for RET/RETI: PC_MUX_SEL=01, PC_LD=1, STACK_POP=1; RETI additionally sets INT_EN=1.
REQ-028 SHALL for CALL: PC_MUX_SEL=00, PC_LD=1, STACK_PUSH=1, RET_ADDR=PC_COUNT+1 (mod 1024).
REQ-029 SHALL for BRANCH: PC_MUX_SEL=00, PC_LD=1, no stack strobe.
REQ-030 SHALL otherwise increment PC_COUNT by 1, wrapping 10'h3FF -> 10'h000, PC_LD=0.
REQ-031 SHALL in INTR: STACK_PUSH=1, RET_ADDR=PC_COUNT (already-updated next PC), PC_MUX_SEL=10, PC_LD=1, clear INT_EN and pending.
REQ-032 SHALL latch INTR rising edges into a pending bit in every non-reset state; pending persists while INT_EN=0.
REQ-033 SHALL evaluate the INTR transition using pending and INT_EN values after that EXEC's SEI/CLI/RETI update.
REQ-034 SHALL apply SEI and CLI both asserted as CLI wins; SEI/CLI take effect at the EXEC exit edge.
REQ-035 SHALL track depth 0..DEPTH_MAX: +1 per push, -1 per pop.
REQ-036 SHALL on push at depth DEPTH_MAX suppress STACK_PUSH, keep depth, set STK_ERR; PC still loads target.
REQ-037 SHALL on pop at depth 0 suppress STACK_POP, set STK_ERR, load PC via PC_MUX_SEL=11 (zero).
REQ-038 SHALL drive PC_MUX_SEL=11 whenever PC_LD=0.

Reset
REQ-039 SHALL on RST_N=0 immediately set STATE=INIT, PC_COUNT=0, INT_EN=0, pending=0, depth=0, STK_ERR=0, PC_LD=0, STACK_PUSH=0, STACK_POP=0, RET_ADDR=0, PC_MUX_SEL=11.
REQ-040 SHALL abandon any in-flight EXEC/INTR on reset with no strobes issued; STK_ERR clears only on reset.

Verification
REQ-041 SHALL verify: release reset, no controls -> INIT, then PC_COUNT 0,1,2 at successive EXEC exits; 10'h3FF wraps to 0.
REQ-042 SHALL verify: PC_COUNT=10'h010, CALL with FROM_IMMED=10'h080 -> push RET_ADDR=10'h011, PC_COUNT=10'h080; later RET with FROM_STACK=10'h011 -> pop, PC_COUNT=10'h011.
REQ-043 SHALL verify: INT_EN=1, INTR pulse during FETCH at PC_COUNT=10'h020 -> INTR state, push 10'h021, PC_COUNT=10'h3FF, INT_EN=0; RETI restores 10'h021, INT_EN=1.
REQ-044 SHALL verify: INT_EN=0, INTR pulse -> no INTR state; SEI later -> INTR taken after that EXEC.
REQ-045 SHALL verify: 16 CALLs -> 16th push suppressed, STK_ERR=1; RET at depth 0 -> no pop, PC_COUNT=0, STK_ERR=1.
REQ-046 SHALL verify: RST_N low mid-INTR -> all outputs at reset values asynchronously, no STACK_PUSH.
